// File: rtl/am_server_mux_if.sv
// Client-side and server-side AM channels of am_server_mux bundled as one interface.
// Client i owns slice i of every per-client vector and message bus.
interface am_server_mux_if #(
  parameter int NUM_CLIENTS = 4,
  parameter int SDARG_BITS  = 32,
  parameter int DATA_BITS   = 512
);
  localparam int MSG_BITS = DATA_BITS + 6 * SDARG_BITS;

  logic [NUM_CLIENTS-1:0]          clt_tx;
  logic [NUM_CLIENTS*MSG_BITS-1:0] clt_tx_msg;
  logic [NUM_CLIENTS-1:0]          clt_tx_full;
  logic [NUM_CLIENTS-1:0]          clt_rx_empty;
  logic [NUM_CLIENTS*MSG_BITS-1:0] clt_rx_msg;
  logic [NUM_CLIENTS-1:0]          clt_rx_pop;
  logic                            svr_tx;
  logic [MSG_BITS-1:0]             svr_tx_msg;
  logic                            svr_tx_full;
  logic                            svr_rx_empty;
  logic [MSG_BITS-1:0]             svr_rx_msg;
  logic                            svr_rx_pop;
  logic [NUM_CLIENTS-1:0]          err_overflow;

  // The mux itself: consumes client pushes and server responses.
  modport slave (
    input  clt_tx, clt_tx_msg, clt_rx_pop, svr_tx_full, svr_rx_empty, svr_rx_msg,
    output clt_tx_full, clt_rx_empty, clt_rx_msg, svr_tx, svr_tx_msg, svr_rx_pop,
           err_overflow
  );

  modport master (
    output clt_tx, clt_tx_msg, clt_rx_pop, svr_tx_full, svr_rx_empty, svr_rx_msg,
    input  clt_tx_full, clt_rx_empty, clt_rx_msg, svr_tx, svr_tx_msg, svr_rx_pop,
           err_overflow
  );
endinterface

// File: rtl/am_server_mux.sv
// N-client active-message mux: per-client request FIFOs arbitrated round-robin onto one
// server port, and server responses steered back to per-client FIFOs by dstid low bits.
module am_server_mux #(
  parameter int NUM_CLIENTS = 4,
  parameter int SDARG_BITS  = 32,
  parameter int DATA_BITS   = 512,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic           clk,
  input  logic           rst,
  am_server_mux_if.slave bus
);
  localparam int MSG_BITS  = DATA_BITS + 6 * SDARG_BITS;
  localparam int CW        = $clog2(NUM_CLIENTS);
  localparam int PW        = $clog2(FIFO_DEPTH);
  localparam int CNTW      = PW + 1;
  localparam int DSTID_LSB = 4 * SDARG_BITS;
  localparam logic [CW-1:0]   LAST_CLIENT = CW'(NUM_CLIENTS - 1);
  localparam logic [CNTW-1:0] DEPTH_COUNT = CNTW'(FIFO_DEPTH);

  logic [NUM_CLIENTS-1:0]               reqFull;
  logic [NUM_CLIENTS-1:0]               reqEmpty;
  logic [NUM_CLIENTS-1:0]               reqErr;
  logic [NUM_CLIENTS-1:0]               grant;
  logic [NUM_CLIENTS-1:0][MSG_BITS-1:0] reqHead;
  logic [NUM_CLIENTS-1:0]               rspFull;
  logic [NUM_CLIENTS-1:0]               rspEmpty;
  logic [NUM_CLIENTS-1:0]               rspErr;
  logic [NUM_CLIENTS-1:0]               errQ;
  logic [CW-1:0]                        lastGrant;
  logic [CW-1:0]                        winner;
  logic                                 found;
  logic                                 svrTx;
  logic [CW-1:0]                        rspIdx;
  logic                                 rspAccept;

  // Round-robin search from lastGrant+1; the k == NUM_CLIENTS step wraps back to lastGrant.
  always_comb begin
    logic [CW-1:0] cand;
    found  = 1'b0;
    winner = lastGrant;
    cand   = '0;
    for (int k = 1; k <= NUM_CLIENTS; k++) begin
      cand = lastGrant + CW'(k);
      if (!found && !reqEmpty[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign svrTx = found && !bus.svr_tx_full && !rst;

  always_comb begin
    grant         = '0;
    grant[winner] = svrTx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lastGrant <= LAST_CLIENT;
    end else if (svrTx) begin
      lastGrant <= winner;
    end
  end

  // A full target FIFO blocks the whole response channel rather than reordering.
  assign rspIdx    = bus.svr_rx_msg[DSTID_LSB +: CW];
  assign rspAccept = !rst && !bus.svr_rx_empty && !rspFull[rspIdx];

  for (genvar i = 0; i < NUM_CLIENTS; i++) begin : gClient
    logic [MSG_BITS-1:0] reqMem [FIFO_DEPTH];
    logic [PW-1:0]       reqWr;
    logic [PW-1:0]       reqRd;
    logic [CNTW-1:0]     reqCnt;
    logic [CNTW-1:0]     reqCntNext;
    logic                reqFullQ;
    logic                reqEmptyQ;
    logic                reqPush;
    logic                reqPop;

    logic [MSG_BITS-1:0] rspMem [FIFO_DEPTH];
    logic [PW-1:0]       rspWr;
    logic [PW-1:0]       rspRd;
    logic [CNTW-1:0]     rspCnt;
    logic [CNTW-1:0]     rspCntNext;
    logic                rspFullQ;
    logic                rspEmptyQ;
    logic                rspPush;
    logic                rspPop;

    // Flags are looked at before this cycle's pop, so a full FIFO never takes a push.
    assign reqPush = bus.clt_tx[i] && !reqFullQ;
    assign reqPop  = grant[i];
    assign reqErr[i] = bus.clt_tx[i] && reqFullQ;

    always_comb begin
      reqCntNext = reqCnt;
      if (reqPush && !reqPop) begin
        reqCntNext = reqCnt + CNTW'(1);
      end else if (!reqPush && reqPop) begin
        reqCntNext = reqCnt - CNTW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        reqWr     <= '0;
        reqRd     <= '0;
        reqCnt    <= '0;
        reqFullQ  <= 1'b0;
        reqEmptyQ <= 1'b1;
      end else begin
        if (reqPush) reqWr <= reqWr + PW'(1);
        if (reqPop)  reqRd <= reqRd + PW'(1);
        reqCnt    <= reqCntNext;
        reqFullQ  <= (reqCntNext == DEPTH_COUNT);
        reqEmptyQ <= (reqCntNext == '0);
      end
    end

    always_ff @(posedge clk) begin
      if (reqPush) reqMem[reqWr] <= bus.clt_tx_msg[i*MSG_BITS +: MSG_BITS];
    end

    assign reqFull[i]  = reqFullQ;
    assign reqEmpty[i] = reqEmptyQ;
    assign reqHead[i]  = reqMem[reqRd];

    assign rspPush   = rspAccept && (rspIdx == CW'(i));
    assign rspPop    = bus.clt_rx_pop[i] && !rspEmptyQ;
    assign rspErr[i] = bus.clt_rx_pop[i] && rspEmptyQ;

    always_comb begin
      rspCntNext = rspCnt;
      if (rspPush && !rspPop) begin
        rspCntNext = rspCnt + CNTW'(1);
      end else if (!rspPush && rspPop) begin
        rspCntNext = rspCnt - CNTW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rspWr     <= '0;
        rspRd     <= '0;
        rspCnt    <= '0;
        rspFullQ  <= 1'b0;
        rspEmptyQ <= 1'b1;
      end else begin
        if (rspPush) rspWr <= rspWr + PW'(1);
        if (rspPop)  rspRd <= rspRd + PW'(1);
        rspCnt    <= rspCntNext;
        rspFullQ  <= (rspCntNext == DEPTH_COUNT);
        rspEmptyQ <= (rspCntNext == '0);
      end
    end

    always_ff @(posedge clk) begin
      if (rspPush) rspMem[rspWr] <= bus.svr_rx_msg;
    end

    assign rspFull[i]  = rspFullQ;
    assign rspEmpty[i] = rspEmptyQ;
    assign bus.clt_rx_msg[i*MSG_BITS +: MSG_BITS] = rspMem[rspRd];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      errQ <= '0;
    end else begin
      errQ <= errQ | reqErr | rspErr;
    end
  end

  assign bus.clt_tx_full  = reqFull;
  assign bus.clt_rx_empty = rspEmpty;
  assign bus.svr_tx       = svrTx;
  assign bus.svr_tx_msg   = reqHead[winner];
  assign bus.svr_rx_pop   = rspAccept;
  assign bus.err_overflow = errQ;
endmodule

// File: tb/tb_am_server_mux.sv
// Directed bench for am_server_mux: a round-robin vector table plus hand-written
// sequences for backpressure, response routing, head-of-line stall and mid-stream reset.
module tb_am_server_mux;
  localparam int NC = 4;
  localparam int SD = 32;
  localparam int DB = 32;
  localparam int MB = DB + 6 * SD;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  am_server_mux_if #(.NUM_CLIENTS(NC), .SDARG_BITS(SD), .DATA_BITS(DB)) bus ();

  am_server_mux #(
    .NUM_CLIENTS(NC), .SDARG_BITS(SD), .DATA_BITS(DB), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  push;
    logic [31:0] seq;
    logic        expTx;
    logic [31:0] expClient;
    logic [31:0] expSeq;
  } rrVec_t;

  rrVec_t rrVecs [14];

  // Message image: data, srcid, dstid, arg0..arg3 with args derived from arg0.
  function automatic logic [MB-1:0] mkMsg(input logic [31:0] src, input logic [31:0] dst,
                                          input logic [31:0] a0);
    return {32'hD000_0000 | a0, src, dst, a0, a0 + 32'd1, a0 + 32'd2, a0 + 32'd3};
  endfunction

  task automatic checkOutput(input string name, input logic [MB-1:0] act,
                             input logic [MB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drives one cycle's inputs just after the falling edge, then lets logic settle.
  task automatic applyStimulus(input logic [3:0] push, input logic [31:0] seq,
                               input logic full, input logic rxEmpty,
                               input logic [MB-1:0] rxMsg, input logic [3:0] rxPop);
    @(negedge clk);
    bus.clt_tx = push;
    for (int i = 0; i < NC; i++) begin
      bus.clt_tx_msg[i*MB +: MB] = mkMsg(32'(i), 32'd0, 32'(i * 16) + seq);
    end
    bus.svr_tx_full  = full;
    bus.svr_rx_empty = rxEmpty;
    bus.svr_rx_msg   = rxMsg;
    bus.clt_rx_pop   = rxPop;
    #1;
  endtask

  task automatic idle();
    applyStimulus(4'b0000, 32'd0, 1'b0, 1'b1, '0, 4'b0000);
  endtask

  task automatic setRr(input int idx, input logic [3:0] push, input logic [31:0] seq,
                       input logic expTx, input logic [31:0] c, input logic [31:0] s);
    rrVecs[idx].push      = push;
    rrVecs[idx].seq       = seq;
    rrVecs[idx].expTx     = expTx;
    rrVecs[idx].expClient = c;
    rrVecs[idx].expSeq    = s;
  endtask

  logic [MB-1:0] r1, r2, r3;
  logic [MB-1:0] hol [5];

  initial begin
    setRr(0,  4'b1111, 0, 1'b0, 0, 0);
    setRr(1,  4'b1111, 1, 1'b1, 0, 0);
    setRr(2,  4'b1111, 2, 1'b1, 1, 0);
    setRr(3,  4'b0000, 0, 1'b1, 2, 0);
    setRr(4,  4'b0000, 0, 1'b1, 3, 0);
    setRr(5,  4'b0000, 0, 1'b1, 0, 1);
    setRr(6,  4'b0000, 0, 1'b1, 1, 1);
    setRr(7,  4'b0000, 0, 1'b1, 2, 1);
    setRr(8,  4'b0000, 0, 1'b1, 3, 1);
    setRr(9,  4'b0000, 0, 1'b1, 0, 2);
    setRr(10, 4'b0000, 0, 1'b1, 1, 2);
    setRr(11, 4'b0000, 0, 1'b1, 2, 2);
    setRr(12, 4'b0000, 0, 1'b1, 3, 2);
    setRr(13, 4'b0000, 0, 1'b0, 0, 0);

    r1 = mkMsg(32'd7, 32'h105, 32'hA1);
    r2 = mkMsg(32'd7, 32'h102, 32'hA2);
    r3 = mkMsg(32'd7, 32'h107, 32'hA3);
    for (int k = 0; k < 5; k++) hol[k] = mkMsg(32'd9, 32'h200, 32'hB0 + 32'(k));

    rst = 1'b1;
    bus.clt_tx = '0;
    bus.clt_tx_msg = '0;
    bus.svr_tx_full = 1'b0;
    bus.svr_rx_empty = 1'b1;
    bus.svr_rx_msg = '0;
    bus.clt_rx_pop = '0;

    // Reset then idle.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset svr_tx", MB'(bus.svr_tx), MB'(1'b0));
    checkOutput("reset svr_rx_pop", MB'(bus.svr_rx_pop), MB'(1'b0));
    checkOutput("reset clt_rx_empty", MB'(bus.clt_rx_empty), MB'(4'b1111));
    checkOutput("reset clt_tx_full", MB'(bus.clt_tx_full), MB'(4'b0000));
    checkOutput("reset err_overflow", MB'(bus.err_overflow), MB'(4'b0000));

    // Round-robin fairness table.
    for (int v = 0; v < 14; v++) begin
      applyStimulus(rrVecs[v].push, rrVecs[v].seq, 1'b0, 1'b1, '0, 4'b0000);
      checkOutput($sformatf("rr[%0d] svr_tx", v), MB'(bus.svr_tx), MB'(rrVecs[v].expTx));
      if (rrVecs[v].expTx) begin
        checkOutput($sformatf("rr[%0d] svr_tx_msg", v), bus.svr_tx_msg,
                    mkMsg(rrVecs[v].expClient, 32'd0,
                          rrVecs[v].expClient * 32'd16 + rrVecs[v].expSeq));
      end
    end

    // Backpressure: client 2 fills its FIFO while the server is full.
    for (int s = 0; s < 4; s++) begin
      applyStimulus(4'b0100, 32'(s), 1'b1, 1'b1, '0, 4'b0000);
      checkOutput("bp svr_tx held", MB'(bus.svr_tx), MB'(1'b0));
      checkOutput("bp not yet full", MB'(bus.clt_tx_full), MB'(4'b0000));
    end
    applyStimulus(4'b0100, 32'd4, 1'b1, 1'b1, '0, 4'b0000);
    checkOutput("bp full flag", MB'(bus.clt_tx_full), MB'(4'b0100));
    checkOutput("bp svr_tx while full", MB'(bus.svr_tx), MB'(1'b0));
    checkOutput("bp err before drop", MB'(bus.err_overflow), MB'(4'b0000));
    for (int s = 0; s < 4; s++) begin
      idle();
      if (s == 0) checkOutput("bp err after drop", MB'(bus.err_overflow), MB'(4'b0100));
      checkOutput($sformatf("bp drain[%0d] svr_tx", s), MB'(bus.svr_tx), MB'(1'b1));
      checkOutput($sformatf("bp drain[%0d] msg", s), bus.svr_tx_msg,
                  mkMsg(32'd2, 32'd0, 32'h20 + 32'(s)));
    end
    idle();
    checkOutput("bp fifth dropped", MB'(bus.svr_tx), MB'(1'b0));
    checkOutput("bp full cleared", MB'(bus.clt_tx_full), MB'(4'b0000));

    // Response routing by dstid low bits.
    applyStimulus(4'b0000, 32'd0, 1'b0, 1'b0, r1, 4'b0000);
    checkOutput("route pop r1", MB'(bus.svr_rx_pop), MB'(1'b1));
    checkOutput("route empty before", MB'(bus.clt_rx_empty), MB'(4'b1111));
    applyStimulus(4'b0000, 32'd0, 1'b0, 1'b0, r2, 4'b0000);
    checkOutput("route pop r2", MB'(bus.svr_rx_pop), MB'(1'b1));
    checkOutput("route empty c1", MB'(bus.clt_rx_empty), MB'(4'b1101));
    checkOutput("route msg c1", bus.clt_rx_msg[1*MB +: MB], r1);
    applyStimulus(4'b0000, 32'd0, 1'b0, 1'b0, r3, 4'b0000);
    checkOutput("route empty c2", MB'(bus.clt_rx_empty), MB'(4'b1001));
    checkOutput("route msg c2", bus.clt_rx_msg[2*MB +: MB], r2);
    idle();
    checkOutput("route no pop idle", MB'(bus.svr_rx_pop), MB'(1'b0));
    checkOutput("route empty c3", MB'(bus.clt_rx_empty), MB'(4'b0001));
    checkOutput("route msg c3", bus.clt_rx_msg[3*MB +: MB], r3);
    applyStimulus(4'b0000, 32'd0, 1'b0, 1'b1, '0, 4'b1110);
    idle();
    checkOutput("route drained", MB'(bus.clt_rx_empty), MB'(4'b1111));
    checkOutput("route err unchanged", MB'(bus.err_overflow), MB'(4'b0100));
    applyStimulus(4'b0000, 32'd0, 1'b0, 1'b1, '0, 4'b1000);
    idle();
    checkOutput("pop-while-empty err", MB'(bus.err_overflow), MB'(4'b1100));
    checkOutput("pop-while-empty flags", MB'(bus.clt_rx_empty), MB'(4'b1111));

    // Head-of-line stall on a full response FIFO 0.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'b0000, 32'd0, 1'b0, 1'b0, hol[k], 4'b0000);
      checkOutput($sformatf("hol fill[%0d] pop", k), MB'(bus.svr_rx_pop), MB'(1'b1));
    end
    applyStimulus(4'b0000, 32'd0, 1'b0, 1'b0, hol[4], 4'b0000);
    checkOutput("hol stall 1", MB'(bus.svr_rx_pop), MB'(1'b0));
    applyStimulus(4'b0000, 32'd0, 1'b0, 1'b0, hol[4], 4'b0000);
    checkOutput("hol stall 2", MB'(bus.svr_rx_pop), MB'(1'b0));
    checkOutput("hol head", bus.clt_rx_msg[0 +: MB], hol[0]);
    applyStimulus(4'b0000, 32'd0, 1'b0, 1'b0, hol[4], 4'b0001);
    checkOutput("hol stall during pop", MB'(bus.svr_rx_pop), MB'(1'b0));
    applyStimulus(4'b0000, 32'd0, 1'b0, 1'b0, hol[4], 4'b0000);
    checkOutput("hol resume", MB'(bus.svr_rx_pop), MB'(1'b1));
    checkOutput("hol next head", bus.clt_rx_msg[0 +: MB], hol[1]);

    // Mid-stream reset with requests queued behind a full server.
    for (int s = 0; s < 3; s++) begin
      applyStimulus(4'b1111, 32'(s), 1'b1, 1'b1, '0, 4'b0000);
    end
    idle();
    rst = 1'b1;
    #1;
    checkOutput("mid rst svr_tx", MB'(bus.svr_tx), MB'(1'b0));
    idle();
    rst = 1'b0;
    #1;
    checkOutput("mid rst svr_tx after", MB'(bus.svr_tx), MB'(1'b0));
    checkOutput("mid rst rx empty", MB'(bus.clt_rx_empty), MB'(4'b1111));
    checkOutput("mid rst tx full", MB'(bus.clt_tx_full), MB'(4'b0000));
    checkOutput("mid rst err cleared", MB'(bus.err_overflow), MB'(4'b0000));
    applyStimulus(4'b1111, 32'd5, 1'b0, 1'b1, '0, 4'b0000);
    checkOutput("mid rst no stale grant", MB'(bus.svr_tx), MB'(1'b0));
    idle();
    checkOutput("mid rst grant valid", MB'(bus.svr_tx), MB'(1'b1));
    checkOutput("mid rst grant client0", bus.svr_tx_msg, mkMsg(32'd0, 32'd0, 32'd5));
    idle();
    checkOutput("mid rst grant client1", bus.svr_tx_msg, mkMsg(32'd1, 32'd0, 32'd21));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
